// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-computing stages.
// STOCH_DEC_BIPOLAR_EN selects the bipolar (signed) readout width.
package stoch_pkg;

  typedef enum logic [1:0] {
    DEC_IDLE  = 2'd0,
    DEC_ACCUM = 2'd1,
    DEC_HOLD  = 2'd2
  } stoch_dec_state_t;

  typedef enum logic [1:0] {
    WIN_HOLD  = 2'd0,
    WIN_CLEAR = 2'd1,
    WIN_LOAD  = 2'd2,
    WIN_INC   = 2'd3
  } win_op_t;

  function automatic int est_width(input int window_log2);
`ifdef STOCH_DEC_BIPOLAR_EN
    return window_log2 + 2;
`else
    return window_log2 + 1;
`endif
  endfunction

endpackage

// File: rtl/stoch_stream_decoder_if.sv
// Bitstream input and estimate handshake between the decoder and its driver/consumer.
// Estimate width follows STOCH_DEC_BIPOLAR_EN through stoch_pkg::est_width.
interface stoch_stream_decoder_if
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
);
  localparam int EST_W = est_width(WINDOW_LOG2);

  logic             bit_in;
  logic             start;
  logic             continuous;
  logic             busy;
  logic [EST_W-1:0] est;
  logic             est_valid;
  logic             est_ready;

  modport master (
    output bit_in, start, continuous, est_ready,
    input  busy, est, est_valid
  );

  modport slave (
    input  bit_in, start, continuous, est_ready,
    output busy, est, est_valid
  );

endinterface

// File: rtl/stoch_window_counter.sv
// Bit-position counter for one decode window; flags the final bit (idx == N-1).
module stoch_window_counter
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic    CLK,
  input  logic    nRST,
  input  win_op_t op,
  output logic    last
);
  localparam logic [WINDOW_LOG2-1:0] LAST_IDX = {WINDOW_LOG2{1'b1}};

  logic [WINDOW_LOG2-1:0] idx_r;

  // index register: load to 1 because the loading cycle already consumed bit 0
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      idx_r <= '0;
    end else begin
      case (op)
        WIN_CLEAR: idx_r <= '0;
        WIN_LOAD:  idx_r <= WINDOW_LOG2'(1);
        WIN_INC:   idx_r <= idx_r + WINDOW_LOG2'(1);
        default:   idx_r <= idx_r;
      endcase
    end
  end

  assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/stoch_stream_decoder.sv
// Counts ones over 2**WINDOW_LOG2 bitstream cycles and presents the estimate on a valid/ready port.
// Define STOCH_DEC_BIPOLAR_EN for the signed 2*ones-N readout; default is the unsigned ones count.
module stoch_stream_decoder
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  stoch_stream_decoder_if.slave bus
);
  localparam int EST_W = est_width(WINDOW_LOG2);
  localparam int CNT_W = WINDOW_LOG2 + 1;
`ifdef STOCH_DEC_BIPOLAR_EN
  localparam logic [EST_W-1:0] N_EST = EST_W'(1) << WINDOW_LOG2;
`endif

  stoch_dec_state_t state_r;
  logic [CNT_W-1:0] count_r;
  logic [EST_W-1:0] est_r;
  logic             est_valid_r;
  logic             busy_r;

  logic [CNT_W-1:0] sum_s;
  logic [EST_W-1:0] est_next_s;
  logic             handshake_s;
  logic             last_s;
  win_op_t          win_op_s;

  assign sum_s       = count_r + CNT_W'(bus.bit_in);
  assign handshake_s = est_valid_r & bus.est_ready;

  stoch_window_counter #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_window (
    .CLK  (CLK),
    .nRST (nRST),
    .op   (win_op_s),
    .last (last_s)
  );

  // window index control, mirrors the FSM transitions below
  always_comb begin
    win_op_s = WIN_HOLD;
    case (state_r)
      DEC_IDLE: begin
        if (bus.start) win_op_s = WIN_LOAD;
        else           win_op_s = WIN_HOLD;
      end
      DEC_ACCUM: begin
        if (last_s) win_op_s = WIN_CLEAR;
        else        win_op_s = WIN_INC;
      end
      DEC_HOLD: begin
        if (handshake_s && bus.continuous) win_op_s = WIN_LOAD;
        else                               win_op_s = WIN_HOLD;
      end
      default: win_op_s = WIN_CLEAR;
    endcase
  end

  // readout conversion, only applied when the estimate register loads
  always_comb begin
`ifdef STOCH_DEC_BIPOLAR_EN
    est_next_s = (EST_W'(sum_s) << 1) - N_EST;
`else
    est_next_s = EST_W'(sum_s);
`endif
  end

  // decoder FSM with ones accumulator, estimate register and handshake
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r     <= DEC_IDLE;
      count_r     <= '0;
      est_r       <= '0;
      est_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        DEC_IDLE: begin
          if (bus.start) begin
            count_r <= CNT_W'(bus.bit_in);
            state_r <= DEC_ACCUM;
            busy_r  <= 1'b1;
          end else begin
            state_r <= DEC_IDLE;
          end
        end
        DEC_ACCUM: begin
          count_r <= sum_s;
          if (last_s) begin
            est_r       <= est_next_s;
            est_valid_r <= 1'b1;
            state_r     <= DEC_HOLD;
          end else begin
            state_r <= DEC_ACCUM;
          end
        end
        DEC_HOLD: begin
          // stalled bits are dropped; a continuous handshake starts the next window on this bit
          if (handshake_s) begin
            est_valid_r <= 1'b0;
            if (bus.continuous) begin
              count_r <= CNT_W'(bus.bit_in);
              state_r <= DEC_ACCUM;
            end else begin
              state_r <= DEC_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= DEC_HOLD;
          end
        end
        default: begin
          state_r     <= DEC_IDLE;
          est_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.est       = est_r;
  assign bus.est_valid = est_valid_r;

endmodule

// File: tb/tb_stoch_stream_decoder.sv
// Randomized self-checking bench for stoch_stream_decoder (WINDOW_LOG2=4, N=16).
module tb_stoch_stream_decoder;
  import stoch_pkg::*;

  localparam int WL = 4;
  localparam int N  = 16;
  localparam int EW = est_width(WL);

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  stoch_stream_decoder_if #(.WINDOW_LOG2(WL)) bus ();

  stoch_stream_decoder #(.WINDOW_LOG2(WL)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic int ones_of(input logic [N-1:0] b);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(b[i]);
    return s;
  endfunction

  // expected readout from a ones count
  function automatic logic [EW-1:0] model_est(input int ones);
`ifdef STOCH_DEC_BIPOLAR_EN
    return EW'(2 * ones - N);
`else
    return EW'(ones);
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drives one window (start with bit 0, then bits 1..N-1); ends in HOLD
  task automatic run_window(input logic [N-1:0] bits);
    for (int i = 0; i < N; i++) begin
      bus.bit_in = bits[i];
      bus.start  = (i == 0);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic consume();
    bus.est_ready = 1'b1;
    tick();
    bus.est_ready = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick();
    tick();
    n_run++;
    if (bus.busy !== 1'b0 || bus.est_valid !== 1'b0 || bus.est !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b est=%0h, want 0 0 0", bus.busy, bus.est_valid, bus.est);
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_all_ones();
    int bad = 0;
    bus.bit_in = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (bus.est_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
      tick();
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ones_latency: %0d early-valid/idle cycles, want 0", bad);
    end
    n_run++;
    if (bus.est_valid !== 1'b1 || bus.est !== model_est(N)) begin
      n_fail++;
      $display("FAIL ones_est: valid=%b est=%0h, want 1 %0h", bus.est_valid, bus.est, model_est(N));
    end
    consume();
    n_run++;
    if (bus.est_valid !== 1'b0 || bus.busy !== 1'b0 || bus.est !== model_est(N)) begin
      n_fail++;
      $display("FAIL ones_after: valid=%b busy=%b est=%0h, want 0 0 %0h",
               bus.est_valid, bus.busy, bus.est, model_est(N));
    end
  endtask

  task automatic test_patterns();
    logic [N-1:0] pats [8];
    pats[0] = 16'h5555;
    pats[1] = 16'h0000;
    pats[2] = 16'hFFFF;
    for (int k = 3; k < 8; k++) pats[k] = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      run_window(pats[k]);
      n_run++;
      if (bus.est_valid !== 1'b1 || bus.est !== model_est(ones_of(pats[k]))) begin
        n_fail++;
        $display("FAIL pattern[%0d]: valid=%b est=%0h, want 1 %0h", k, bus.est_valid, bus.est,
                 model_est(ones_of(pats[k])));
      end
      consume();
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      bus.bit_in = (i % 2 == 0);
      bus.start  = (i == 0 || i == 3 || i == 10);
      tick();
    end
    bus.start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (bus.est_valid !== 1'b1 || bus.est !== model_est(8)) bad++;
      bus.bit_in = 1'($urandom);
      bus.start  = 1'($urandom);
      tick();
    end
    bus.start = 1'b0;
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
    end
    n_run++;
    if (bus.est_valid !== 1'b1 || bus.est !== model_est(8) || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_end: valid=%b est=%0h busy=%b, want 1 %0h 1",
               bus.est_valid, bus.est, bus.busy, model_est(8));
    end
    consume();
  endtask

  task automatic test_continuous();
    int ones = 0;
    int bad  = 0;
    bus.continuous = 1'b1;
    bus.est_ready  = 1'b1;
    for (int k = 1; k <= 3 * N; k++) begin
      bus.bit_in = 1'($urandom);
      bus.start  = (k == 1);
      ones += int'(bus.bit_in);
      tick();
      if (k % N == 0) begin
        if (bus.est_valid !== 1'b1 || bus.est !== model_est(ones)) bad++;
        ones = 0;
      end else if (bus.est_valid !== 1'b0) begin
        bad++;
      end
    end
    bus.start = 1'b0;
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL continuous: %0d wrong cycles, want 0", bad);
    end
    bus.continuous = 1'b0;
    tick();
    bus.est_ready = 1'b0;
    n_run++;
    if (bus.busy !== 1'b0 || bus.est_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL continuous_stop: busy=%b valid=%b, want 0 0", bus.busy, bus.est_valid);
    end
  endtask

  task automatic test_midreset();
    logic [N-1:0] b;
    bus.bit_in = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    n_run++;
    if (bus.busy !== 1'b0 || bus.est_valid !== 1'b0 || bus.est !== '0) begin
      n_fail++;
      $display("FAIL midreset: busy=%b valid=%b est=%0h, want 0 0 0", bus.busy, bus.est_valid, bus.est);
    end
    b = 16'($urandom);
    run_window(b);
    n_run++;
    if (bus.est_valid !== 1'b1 || bus.est !== model_est(ones_of(b))) begin
      n_fail++;
      $display("FAIL midreset_fresh: valid=%b est=%0h, want 1 %0h", bus.est_valid, bus.est,
               model_est(ones_of(b)));
    end
    consume();
  endtask

  task automatic test_ready_early();
    logic [N-1:0] b;
    b = 16'($urandom);
    bus.est_ready  = 1'b1;
    bus.continuous = 1'b0;
    run_window(b);
    n_run++;
    if (bus.est_valid !== 1'b1 || bus.est !== model_est(ones_of(b))) begin
      n_fail++;
      $display("FAIL early_est: valid=%b est=%0h, want 1 %0h", bus.est_valid, bus.est,
               model_est(ones_of(b)));
    end
    bus.bit_in = 1'b1;
    tick();
    n_run++;
    if (bus.est_valid !== 1'b0 || bus.busy !== 1'b0 || bus.est !== model_est(ones_of(b))) begin
      n_fail++;
      $display("FAIL early_single: valid=%b busy=%b est=%0h, want 0 0 %0h",
               bus.est_valid, bus.busy, bus.est, model_est(ones_of(b)));
    end
    bus.est_ready = 1'b0;
  endtask

  initial begin
    bus.bit_in     = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.est_ready  = 1'b0;
    test_reset();
    test_all_ones();
    test_patterns();
    test_stall();
    test_continuous();
    test_midreset();
    test_ready_early();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
